// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch sequencer feeding instruction memory.
// Chooses the next fetch address from the sequential, branch, jump, call and
// return sources, with a small return-address stack and a RUN/HALTED/FAULT
// control FSM. The PC is registered, so no input reaches pccounter
// combinationally.
module pc_fetch_unit #(
  parameter int unsigned     PC_W         = 8,
  parameter int unsigned     STACK_DEPTH  = 4,
  parameter logic [PC_W-1:0] RESET_VECTOR = 8'h00
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           halt_req,
  input  logic                           resume,
  input  logic                           branch_taken,
  input  logic [4:0]                     branch_offset,
  input  logic                           jump,
  input  logic                           call,
  input  logic                           ret,
  input  logic [PC_W-1:0]                jump_target,
  output logic [PC_W-1:0]                pccounter,
  output logic                           fetch_valid,
  output logic                           halted,
  output logic                           stack_overflow,
  output logic                           stack_underflow,
  output logic [$clog2(STACK_DEPTH):0]   stack_count
);

  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

  // Control FSM encoding; the spare code is treated as a fault.
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  // Sign-extend the 5-bit branch immediate to the PC width.
  function automatic logic [PC_W-1:0] sext_offset(input logic [4:0] off);
    sext_offset = {{(PC_W-5){off[4]}}, off};
  endfunction

  // Sequential successor of an address, wrapping modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_plus_one(input logic [PC_W-1:0] pc);
    pc_plus_one = pc + PC_ONE;
  endfunction

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Return-address storage; entry k holds the k-th oldest live return address.
  logic [PC_W-1:0]  stack_q [STACK_DEPTH];

  logic             push_s;
  logic [PC_W-1:0]  push_data_s;
  logic [IDX_W-1:0] push_idx_s;
  logic [IDX_W-1:0] top_idx_s;
  logic [PC_W-1:0]  top_data_s;
  logic             stack_empty_s;
  logic             stack_full_s;

  // Stack bookkeeping derived from the occupancy counter.
  always_comb begin
    stack_empty_s = (cnt_q == {CNT_W{1'b0}});
    stack_full_s  = !(cnt_q < DEPTH_C);
    push_idx_s    = cnt_q[IDX_W-1:0];
    top_idx_s     = cnt_q[IDX_W-1:0] - IDX_ONE;
    top_data_s    = stack_q[top_idx_s];
  end

  // Next-state selection: FSM transitions and next-PC priority.
  always_comb begin
    pc_d        = pc_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    push_s      = 1'b0;
    push_data_s = pc_plus_one(pc_q);

    if (enable) begin
      case (state_q)
        ST_RUN: begin
          if (halt_req) begin
            state_d = ST_HALTED;
          end else if (ret) begin
            // A ret shadows any call in the same cycle.
            if (!stack_empty_s) begin
              pc_d  = top_data_s;
              cnt_d = cnt_q - CNT_ONE;
            end else begin
              unf_d   = 1'b1;
              state_d = ST_FAULT;
            end
          end else if (call) begin
            if (!stack_full_s) begin
              push_s = 1'b1;
              pc_d   = jump_target;
              cnt_d  = cnt_q + CNT_ONE;
            end else begin
              ovf_d   = 1'b1;
              state_d = ST_FAULT;
            end
          end else if (jump) begin
            pc_d = jump_target;
          end else if (branch_taken) begin
            pc_d = pc_q + sext_offset(branch_offset);
          end else begin
            pc_d = pc_plus_one(pc_q);
          end
        end
        ST_HALTED: begin
          // Control-flow requests are ignored while halted.
          if (resume && !halt_req) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HALTED;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_FAULT;
        end
      endcase
    end else begin
      // Stall: every piece of state holds.
      state_d = state_q;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      state_q <= ST_RUN;
      cnt_q   <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address write port; contents need no reset since the counter guards reads.
  always_ff @(posedge clock) begin
    if (!reset && push_s) begin
      stack_q[push_idx_s] <= push_data_s;
    end
  end

  assign pccounter       = pc_q;
  assign fetch_valid     = (state_q == ST_RUN) && enable;
  assign halted          = (state_q == ST_HALTED);
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;
  assign stack_count     = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a queue-based reference model is
// compared against the DUT every negative clock edge, and directed scenarios
// add literal expectations that pin both the DUT and the model.
module tb_pc_fetch_unit;

  localparam int DEPTH = 4;
  localparam int M_RUN = 0;
  localparam int M_HALT = 1;
  localparam int M_FAULT = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       halt_req = 1'b0;
  logic       resume = 1'b0;
  logic       branch_taken = 1'b0;
  logic [4:0] branch_offset = 5'd0;
  logic       jump = 1'b0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [7:0] jump_target = 8'h00;
  logic [7:0] pccounter;
  logic       fetch_valid;
  logic       halted;
  logic       stack_overflow;
  logic       stack_underflow;
  logic [2:0] stack_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state
  int m_pc = 0;
  int m_state = M_RUN;
  int m_stack[$];
  int m_ovf = 0;
  int m_unf = 0;

  pc_fetch_unit dut (
    .clock(clock), .reset(reset), .enable(enable), .halt_req(halt_req),
    .resume(resume), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .call(call), .ret(ret), .jump_target(jump_target),
    .pccounter(pccounter), .fetch_valid(fetch_valid), .halted(halted),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow),
    .stack_count(stack_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the rules to the model using the inputs present at this edge.
  task automatic model_step();
    int off;
    if (reset) begin
      m_pc = 0; m_state = M_RUN; m_stack.delete(); m_ovf = 0; m_unf = 0;
    end else if (enable) begin
      if (m_state == M_RUN) begin
        if (halt_req) m_state = M_HALT;
        else if (ret) begin
          if (m_stack.size() > 0) m_pc = m_stack.pop_back();
          else begin m_unf = 1; m_state = M_FAULT; end
        end else if (call) begin
          if (m_stack.size() < DEPTH) begin
            m_stack.push_back((m_pc + 1) % 256);
            m_pc = int'(jump_target);
          end else begin m_ovf = 1; m_state = M_FAULT; end
        end else if (jump) m_pc = int'(jump_target);
        else if (branch_taken) begin
          off = int'(branch_offset);
          if (off >= 16) off = off - 32;
          m_pc = (m_pc + off + 256) % 256;
        end else m_pc = (m_pc + 1) % 256;
      end else if (m_state == M_HALT) begin
        if (resume && !halt_req) m_state = M_RUN;
      end
    end
  endtask

  // One clock: model follows the edge, inputs may change 2 time units later.
  task automatic cyc();
    @(posedge clock);
    model_step();
    #2;
  endtask

  task automatic idle();
    halt_req = 1'b0; resume = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    call = 1'b0; ret = 1'b0; enable = 1'b1;
  endtask

  task automatic lit_pc(input string name, input int exp);
    chk(name, 32'(pccounter), 32'(exp));
    chk({name, "_model"}, 32'(m_pc), 32'(exp));
  endtask

  task automatic lit_cnt(input string name, input int exp);
    chk(name, 32'(stack_count), 32'(exp));
  endtask

  task automatic go_to(input logic [7:0] tgt);
    idle(); jump = 1'b1; jump_target = tgt; cyc(); jump = 1'b0;
  endtask

  // Compare process: DUT against the model on every cycle once reset has been seen.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("pc", 32'(pccounter), 32'(m_pc));
      chk("fetch_valid", 32'(fetch_valid), 32'((m_state == M_RUN) && enable));
      chk("halted", 32'(halted), 32'(m_state == M_HALT));
      chk("overflow", 32'(stack_overflow), 32'(m_ovf));
      chk("underflow", 32'(stack_underflow), 32'(m_unf));
      chk("stack_count", 32'(stack_count), 32'(m_stack.size()));
    end
  end

  initial begin
    cyc(); cyc();
    chk_en = 1'b1;
    reset = 1'b0;
    lit_pc("reset_pc", 8'h00);
    lit_cnt("reset_cnt", 0);
    chk("reset_fv", 32'(fetch_valid), 32'd1);
    chk("reset_ovf", 32'(stack_overflow), 32'd0);

    // Sequential increment and wrap
    cyc(); lit_pc("seq1", 8'h01);
    cyc(); lit_pc("seq2", 8'h02);
    cyc(); lit_pc("seq3", 8'h03);
    go_to(8'hFF); lit_pc("jmp_ff", 8'hFF);
    cyc(); lit_pc("wrap_ff", 8'h00);

    // Branches in both directions
    go_to(8'h0A);
    branch_taken = 1'b1; branch_offset = 5'b11101; cyc(); lit_pc("br_m3", 8'h07);
    branch_offset = 5'b01111; cyc(); lit_pc("br_p15", 8'h16);
    go_to(8'h02);
    branch_taken = 1'b1; branch_offset = 5'b11101; cyc(); lit_pc("br_wrap_dn", 8'hFF);
    go_to(8'hFA);
    branch_taken = 1'b1; branch_offset = 5'b01111; cyc(); lit_pc("br_wrap_up", 8'h09);
    branch_taken = 1'b1; branch_offset = 5'b10000; cyc(); lit_pc("br_m16", 8'hF9);
    idle();

    // Call / return
    go_to(8'h05);
    call = 1'b1; jump_target = 8'h40; cyc(); call = 1'b0;
    lit_pc("call_pc", 8'h40); lit_cnt("call_cnt", 1);
    cyc(); cyc(); lit_pc("after_call", 8'h42);
    ret = 1'b1; cyc(); ret = 1'b0;
    lit_pc("ret_pc", 8'h06); lit_cnt("ret_cnt", 0);

    // LIFO order with two nested calls
    call = 1'b1; jump_target = 8'h10; cyc();
    jump_target = 8'h20; cyc(); call = 1'b0;
    lit_cnt("nest_cnt", 2);
    ret = 1'b1; cyc(); lit_pc("lifo1", 8'h11);
    cyc(); lit_pc("lifo2", 8'h07); ret = 1'b0;

    // Fill the stack, then overflow into FAULT
    call = 1'b1;
    jump_target = 8'h10; cyc();
    jump_target = 8'h20; cyc();
    jump_target = 8'h30; cyc();
    jump_target = 8'h40; cyc();
    lit_cnt("full_cnt", 4); lit_pc("full_pc", 8'h40);
    jump_target = 8'h50; cyc(); call = 1'b0;
    lit_pc("ovf_pc", 8'h40); lit_cnt("ovf_cnt", 4);
    chk("ovf_flag", 32'(stack_overflow), 32'd1);
    chk("ovf_fv", 32'(fetch_valid), 32'd0);
    jump = 1'b1; jump_target = 8'h99; ret = 1'b1; branch_taken = 1'b1; resume = 1'b1;
    cyc(); cyc(); idle();
    lit_pc("fault_frozen", 8'h40); lit_cnt("fault_cnt", 4);
    reset = 1'b1; cyc(); reset = 1'b0;
    lit_pc("rst2_pc", 8'h00); lit_cnt("rst2_cnt", 0);
    chk("rst2_ovf", 32'(stack_overflow), 32'd0);

    // Underflow into FAULT
    ret = 1'b1; cyc(); ret = 1'b0;
    chk("unf_flag", 32'(stack_underflow), 32'd1);
    lit_pc("unf_pc", 8'h00);
    chk("unf_fv", 32'(fetch_valid), 32'd0);
    cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("rst3_unf", 32'(stack_underflow), 32'd0);

    // Simultaneous call+jump+branch: call wins
    go_to(8'h10);
    call = 1'b1; jump = 1'b1; branch_taken = 1'b1; branch_offset = 5'd5;
    jump_target = 8'h80; cyc(); idle();
    lit_pc("multi_pc", 8'h80); lit_cnt("multi_cnt", 1);
    // Call and ret together: ret wins
    call = 1'b1; ret = 1'b1; jump_target = 8'hC0; cyc(); idle();
    lit_pc("callret_pc", 8'h11); lit_cnt("callret_cnt", 0);

    // Halt / resume / stall
    go_to(8'h20);
    halt_req = 1'b1; cyc(); halt_req = 1'b0;
    lit_pc("halt_pc", 8'h20);
    chk("halt_flag", 32'(halted), 32'd1);
    jump = 1'b1; jump_target = 8'h77; cyc(); jump = 1'b0;
    lit_pc("halt_jmp_ignored", 8'h20);
    resume = 1'b1; halt_req = 1'b1; cyc();
    chk("resume_blocked", 32'(halted), 32'd1);
    halt_req = 1'b0; cyc(); resume = 1'b0;
    chk("resumed", 32'(halted), 32'd0);
    lit_pc("resume_pc", 8'h20);
    cyc(); lit_pc("post_resume", 8'h21);
    enable = 1'b0; branch_taken = 1'b1; branch_offset = 5'd5; halt_req = 1'b1;
    cyc(); cyc(); cyc();
    lit_pc("stall_pc", 8'h21);
    chk("stall_fv", 32'(fetch_valid), 32'd0);
    chk("stall_no_halt", 32'(halted), 32'd0);
    idle(); cyc(); lit_pc("unstall", 8'h22);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch sequencer, directly upstream of the instruction memory.
- Drives the 8-bit `pccounter` address into instruction memory every cycle.
- Computes the next PC from:
  - sequential increment;
  - PC-relative branch, using the same 5-bit signed immediate field the memory stage extracts;
  - absolute jump;
  - call/return through a small hardware return-address stack.
- Also provides halt/resume control and a sticky fault state.

Parameters:
- PC_W, 8, width of the program counter and address bus.
- STACK_DEPTH, 4, number of return-address stack entries (power of two, 2..8).
- RESET_VECTOR, 8'h00, PC value loaded on reset.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  0 = stall: PC, stack and FSM hold, all requests ignored.
- halt_req  input  1  request to stop fetching.
- resume  input  1  leave HALTED.
- branch_taken  input  1  take a PC-relative branch.
- branch_offset  input  5  two's-complement offset, sign-extended to PC_W.
- jump  input  1  absolute jump to jump_target.
- call  input  1  push return address, jump to jump_target.
- ret  input  1  pop return address into the PC.
- jump_target  input  PC_W  absolute target for jump/call.
- pccounter  output  PC_W  current fetch address (registered).
- fetch_valid  output  1  1 when state==RUN and enable==1.
- halted  output  1  1 when state==HALTED.
- stack_overflow  output  1  sticky; set by a call when the stack is full.
- stack_underflow  output  1  sticky; set by a ret when the stack is empty.
- stack_count  output  clog2(STACK_DEPTH)+1  current stack occupancy.

Behaviour:

Reset (synchronous; evaluated on clock edge, overrides everything including mid-operation):
- pccounter = RESET_VECTOR.
- state = RUN.
- stack_count = 0.
- stack_overflow = 0, stack_underflow = 0.
- halted = 0.
- Stack contents are don't-care.

FSM states:
- RUN:
  - halt_req & enable -> HALTED.
  - Illegal call/ret -> FAULT.
  - Otherwise stays in RUN.
- HALTED:
  - PC and stack hold.
  - resume & enable & !halt_req -> RUN.
  - resume together with halt_req -> stays HALTED.
  - branch/jump/call/ret are ignored.
- FAULT:
  - PC, stack and flags frozen; fetch_valid = 0.
  - Exit only via reset.

Timing:
- Inputs are sampled at the rising edge.
- The new pccounter is visible 1 cycle later (one-cycle latency).
- No combinational path from inputs to pccounter.

Next-PC priority in RUN with enable=1 (highest first):
1. halt_req: PC holds; enter HALTED.
2. ret:
   - If stack_count>0: PC = top entry, stack_count-1.
   - If stack empty: stack_underflow = 1, state = FAULT, PC holds.
3. call:
   - If stack_count<STACK_DEPTH: push PC+1 (mod 2^PC_W), PC = jump_target, stack_count+1.
   - If stack full: stack_overflow = 1, state = FAULT, PC holds, stack unchanged.
4. jump: PC = jump_target.
5. branch_taken: PC = PC + sext(branch_offset), mod 2^PC_W.
6. Default: PC = PC + 1, mod 2^PC_W.

Arithmetic and edge cases:
- Offset range is -16..+15.
- 8'hFF + 1 wraps to 8'h00.
- Branches wrap in both directions.
- Simultaneous requests resolve by the priority above; lower-priority requests are dropped, not queued.
- Call and ret in the same cycle: the ret is performed and the call is dropped.
- enable=0:
  - Nothing changes, including FSM transitions and sticky flags.
  - fetch_valid = 0.

Return-address stack:
- LIFO with pointer = stack_count.
- Entries above stack_count are not readable.

Test Plan:
1. Reset then 3 cycles with no requests -> pccounter 0x00, 0x01, 0x02, 0x03; fetch_valid=1. With PC=0xFF, one idle cycle -> 0x00.
2. At PC=0x0A:
   - branch_taken with offset 5'b11101 (-3) -> PC=0x07.
   - Then offset 5'b01111 (+15) -> PC=0x16.
   - At PC=0x02 with -3 -> PC=0xFF.
3. At PC=0x05:
   - call with target 0x40 -> PC=0x40, stack_count=1.
   - Two idle cycles -> PC=0x42.
   - ret -> PC=0x06, stack_count=0.
4. Four nested calls succeed (stack_count=4). Fifth call -> stack_overflow=1, PC unchanged, fetch_valid=0. Further requests are ignored until reset; reset clears all state.
5. ret with empty stack -> stack_underflow=1, FAULT. Separately, call+jump+branch asserted together at PC=0x10, target 0x80 -> PC=0x80, 0x11 pushed.
6. halt_req at PC=0x20:
   - PC holds at 0x20, halted=1; a jump during HALTED is ignored.
   - resume -> RUN; next idle cycle PC=0x21.
   - enable=0 for 3 cycles with branch asserted -> PC unchanged.
